// File: rtl/input_event_collector.sv
// Button front end: synchronise, debounce, edge-detect and frame-timed
// auto-repeat for N buttons, with sticky event flags cleared by ack.
module input_event_collector #(
    parameter int NUM_BUTTONS     = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    input  logic                   frame_tick,
    input  logic                   ack,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic [NUM_BUTTONS-1:0] repeat_evt,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   event_valid,
    output logic                   all_released
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [CW-1:0]  DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DLY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST = RCW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_e;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] r_held_d;
    logic [NUM_BUTTONS-1:0] r_pressed;
    logic [NUM_BUTTONS-1:0] r_released;
    logic [NUM_BUTTONS-1:0] r_repeat;

    logic [NUM_BUTTONS-1:0] w_held;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_fall;
    logic [NUM_BUTTONS-1:0] w_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
        logic [CW-1:0]  r_dcnt;
        logic           r_held_b;
        rpt_state_e     r_state;
        rpt_state_e     w_state_nxt;
        logic [RCW-1:0] r_rcnt;
        logic [RCW-1:0] w_rcnt_nxt;
        logic           w_fire_c;

        // held toggles only after DEBOUNCE_CYCLES consecutive mismatches
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_dcnt   <= '0;
                r_held_b <= 1'b0;
            end else if (r_sync2[gi] == r_held_b) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_LAST) begin
                r_held_b <= ~r_held_b;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + CW'(1);
            end
        end

        assign w_held[gi] = r_held_b;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
            end
        end

        // release wins over a coincident frame_tick
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_fire_c    = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    w_rcnt_nxt = '0;
                    if (r_held_b) begin
                        w_state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!r_held_b) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (frame_tick) begin
                        if (r_rcnt == DLY_LAST) begin
                            w_fire_c    = 1'b1;
                            w_rcnt_nxt  = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_rcnt_nxt = r_rcnt + RCW'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!r_held_b) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (frame_tick) begin
                        if (r_rcnt == RATE_LAST) begin
                            w_fire_c   = 1'b1;
                            w_rcnt_nxt = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + RCW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end

        assign w_fire[gi] = w_fire_c;
    end

    assign w_rise = w_held & ~r_held_d;
    assign w_fall = ~w_held & r_held_d;

    // ack clears old flags, but same-cycle events still latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_held_d   <= '0;
            r_pressed  <= '0;
            r_released <= '0;
            r_repeat   <= '0;
        end else begin
            r_held_d   <= w_held;
            r_pressed  <= (ack ? '0 : r_pressed) | w_rise;
            r_released <= (ack ? '0 : r_released) | w_fall;
            r_repeat   <= (ack ? '0 : r_repeat) | w_fire;
        end
    end

    assign pressed      = r_pressed;
    assign released     = r_released;
    assign repeat_evt   = r_repeat;
    assign held         = w_held;
    assign event_valid  = |{r_pressed, r_released, r_repeat};
    assign all_released = ~|w_held;

endmodule

// File: tb/tb_input_event_collector.sv
// Scoreboard bench for input_event_collector: a per-edge behavioural model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_input_event_collector;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 3;
    localparam int RR = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] buttons_in = '0;
    logic         frame_tick = 1'b0;
    logic         ack = 1'b0;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
    logic [N-1:0] repeat_evt;
    logic [N-1:0] held;
    logic         event_valid;
    logic         all_released;

    input_event_collector #(
        .NUM_BUTTONS    (N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buttons_in  (buttons_in),
        .frame_tick  (frame_tick),
        .ack         (ack),
        .pressed     (pressed),
        .released    (released),
        .repeat_evt  (repeat_evt),
        .held        (held),
        .event_valid (event_valid),
        .all_released(all_released)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] rp;
        logic [N-1:0] h;
        logic         ev;
        logic         ar;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (values as seen after the latest edge)
    logic [N-1:0] m_in1, m_in2;
    logic [N-1:0] m_held, m_hprev;
    logic [N-1:0] m_p, m_r, m_rp;
    int           m_run[N];
    int           m_ticks[N];

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s @%0t: got %b, expected %b",
                         name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] np, nr, nf;
        exp_t         e;
        if (!reset) begin
            m_in1 = '0; m_in2 = '0; m_held = '0; m_hprev = '0;
            m_p = '0; m_r = '0; m_rp = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_ticks[i] = 0;
            end
        end else begin
            np = m_held & ~m_hprev;
            nr = ~m_held & m_hprev;
            nf = '0;
            // repeats: tick number RD, then every RR ticks, while held
            for (int i = 0; i < N; i++) begin
                if (frame_tick && m_held[i] && m_hprev[i]) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == RD ||
                        (m_ticks[i] > RD && (m_ticks[i] - RD) % RR == 0))
                        nf[i] = 1'b1;
                end
                if (!m_held[i]) m_ticks[i] = 0;
            end
            m_p  = (ack ? '0 : m_p) | np;
            m_r  = (ack ? '0 : m_r) | nr;
            m_rp = (ack ? '0 : m_rp) | nf;
            m_hprev = m_held;
            for (int i = 0; i < N; i++) begin
                if (m_in2[i] != m_held[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_held[i] = ~m_held[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_in2 = m_in1;
            m_in1 = buttons_in;
        end
        e.p  = m_p;
        e.r  = m_r;
        e.rp = m_rp;
        e.h  = m_held;
        e.ev = |{m_p, m_r, m_rp};
        e.ar = ~|m_held;
        q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pressed", pressed, e.p);
            check("released", released, e.r);
            check("repeat_evt", repeat_evt, e.rp);
            check("held", held, e.h);
            check("event_valid", N'(event_valid), N'(e.ev));
            check("all_released", N'(all_released), N'(e.ar));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        int hedge;
        int pedge;

        // Reset with all buttons pressed, then measure press latency
        buttons_in = '1;
        reset = 1'b0;
        steps(5);
        reset = 1'b1;
        hedge = -1;
        pedge = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (hedge < 0 && held == 5'b11111) hedge = k;
            if (pedge < 0 && pressed == 5'b11111) pedge = k;
        end
        check_int("held_latency", hedge, 1 + DB);
        check_int("pressed_latency", pedge, 2 + DB);

        buttons_in = '0;
        steps(12);
        pulse_ack();
        steps(3);

        // Short glitch must be filtered
        buttons_in[0] = 1'b1;
        steps(3);
        buttons_in[0] = 1'b0;
        steps(10);
        check("glitch_held", held, '0);
        check("glitch_flags", pressed | released, '0);

        // 10-cycle pulse
        buttons_in[0] = 1'b1;
        steps(10);
        buttons_in[0] = 1'b0;
        steps(20);
        pulse_ack();

        // Ack racing a new press on button 3
        for (int off = 0; off < 6; off++) begin
            buttons_in[2] = 1'b1;
            steps(10);
            buttons_in[3] = 1'b1;
            steps(3 + off);
            pulse_ack();
            steps(10);
            pulse_ack();
            buttons_in[3:2] = 2'b00;
            steps(12);
            pulse_ack();
        end

        // Auto-repeat on button 4 with periodic frame ticks
        buttons_in[4] = 1'b1;
        for (int f = 0; f < 40; f++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            steps(3);
            if (repeat_evt[4]) pulse_ack();
        end
        buttons_in[4] = 1'b0;
        for (int f = 0; f < 10; f++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            steps(2);
        end
        pulse_ack();

        // Release coinciding with repeat-firing frame ticks
        for (int off = 0; off < 4; off++) begin
            buttons_in[4] = 1'b1;
            steps(12);
            frame_tick = 1'b1;
            steps(off);
            buttons_in[4] = 1'b0;
            steps(10);
            frame_tick = 1'b0;
            steps(2);
            pulse_ack();
        end

        // Multi-channel press and staggered release
        buttons_in = 5'b01010;
        steps(15);
        buttons_in = 5'b01000;
        steps(15);
        buttons_in = 5'b00000;
        steps(15);
        pulse_ack();

        // Randomised traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0)
                    buttons_in[i] = ~buttons_in[i];
            frame_tick = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 599) != 0);
            step();
        end
        reset = 1'b1;
        ack = 1'b0;
        frame_tick = 1'b0;
        buttons_in = '0;
        steps(20);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
